// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic array front end.
// The skew helper maps a stream cycle and a lane onto the activation row that lane carries.
package tpu_pkg;

  localparam int DEF_K = 2;
  localparam int DEF_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN
  } feeder_state_t;

  typedef struct packed {
    logic        vld;
    logic [15:0] row;
  } skew_t;

  // Lane `lane` carries row (t - lane) while that row index lies inside the matrix.
  function automatic skew_t skew_sel(input int t, input int lane, input int k = DEF_K);
    skew_t s;
    s.vld = (t >= lane) && ((t - lane) < k);
    s.row = s.vld ? 16'(t - lane) : 16'd0;
    return s;
  endfunction

endpackage

// File: rtl/systolic_feeder.sv
// Job sequencer feeding a KxK weight-stationary systolic array: weight load,
// diagonally skewed activation stream, drain window, then a done pulse.
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int K            = DEF_K,
  parameter int W            = DEF_W,
  parameter int DRAIN_CYCLES = 2 * K
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [K-1:0][K-1:0][W-1:0] in_act,
  input  logic [K-1:0][K-1:0][W-1:0] in_wgt,
  output logic                       load_weights,
  output logic [K-1:0][K-1:0][W-1:0] weights,
  output logic                       start,
  output logic [K-1:0][W-1:0]        data,
  output logic                       done,
  output logic                       busy
);

  localparam int TW = $clog2(2 * K - 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int RW = (K > 1) ? $clog2(K) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(2 * K - 2);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

  feeder_state_t              state;
  logic [TW-1:0]              t;
  logic [DW-1:0]              d;
  logic [K-1:0][K-1:0][W-1:0] act_q;
  logic [K-1:0][K-1:0][W-1:0] wgt_q;
  logic                       accept;

  assign in_ready = (state == IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  // Latched matrices survive flush and done; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      d     <= '0;
      act_q <= '0;
      wgt_q <= '0;
    end else if (flush) begin
      state <= IDLE;
      t     <= '0;
      d     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            act_q <= in_act;
            wgt_q <= in_wgt;
            state <= LOAD_W;
          end
        end
        LOAD_W: begin
          t     <= '0;
          state <= STREAM;
        end
        STREAM: begin
          if (t == T_LAST) begin
            t     <= '0;
            d     <= '0;
            state <= DRAIN;
          end else begin
            t <= t + TW'(1);
          end
        end
        DRAIN: begin
          if (d == D_LAST) begin
            d     <= '0;
            state <= IDLE;
          end else begin
            d <= d + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign load_weights = (state == LOAD_W);
  assign start        = (state == STREAM);
  assign done         = (state == DRAIN) && (d == D_LAST);
  assign weights      = load_weights ? wgt_q : '0;

  for (genvar i = 0; i < K; i++) begin : g_lane
    skew_t         sel;
    logic [RW-1:0] row;
    assign sel     = skew_sel(int'(t), i, K);
    assign row     = RW'(sel.row);
    assign data[i] = (start && sel.vld) ? act_q[row][i] : '0;
  end

endmodule
